// File: rtl/hello_master.sv
// rtl/hello_master.sv - Wishbone classic single-transfer initiator with command/response handshake
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_we, cmd_adr, cmd_dat    command payload (1 = write)
//   rsp_valid, rsp_dat, rsp_err one-cycle completion pulse, read data, timeout flag
//   wb_*_o, wb_dat_i, wb_ack_i  Wishbone classic initiator side
//   debug_led                   toggles on every completed command
//
// Optional feature: define HELLO_MASTER_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT stb cycles without ack (rsp_err = 1). Undefined: waits forever for ack.

module hello_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        debug_led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   cmd_take;
    logic   bus_done;
    logic   bus_abort;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("hello_master: TIMEOUT must be within 1..65535");
        end
    endgenerate

    assign cmd_ready = (state == IDLE);
    assign cmd_take  = cmd_ready && cmd_valid;
    // Ack only counts while a cycle is actually on the bus.
    assign bus_done  = (state == BUS) && wb_ack_i;

`ifdef HELLO_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;

    // An ack in the same cycle as the last allowed one wins over the abort.
    assign bus_abort = (state == BUS) && !wb_ack_i && (to_cnt == TO_LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt  <= 16'd0;
            rsp_err <= 1'b0;
        end else begin
            if (cmd_take) begin
                to_cnt <= 16'd0;
            end else if (state == BUS && !wb_ack_i) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (bus_done) begin
                rsp_err <= 1'b0;
            end else if (bus_abort) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    assign bus_abort = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_valid) state_nxt = BUS;
            BUS:  if (bus_done || bus_abort) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wb_adr_o  <= 32'd0;
            wb_dat_o  <= 32'd0;
            wb_sel_o  <= 4'd0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            debug_led <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (cmd_take) begin
                wb_adr_o <= cmd_adr;
                wb_dat_o <= cmd_dat;
                wb_we_o  <= cmd_we;
                wb_sel_o <= 4'hF;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end
            // rsp_valid is registered on the terminating edge, so it is high
            // for exactly the single RESP cycle.
            if (bus_done || bus_abort) begin
                wb_cyc_o  <= 1'b0;
                wb_stb_o  <= 1'b0;
                rsp_valid <= 1'b1;
                debug_led <= ~debug_led;
            end
            if (bus_done && !wb_we_o) begin
                rsp_dat <= wb_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_hello_master.sv
// tb/tb_hello_master.sv - directed self-checking bench for hello_master

module tb_hello_master;

`ifdef HELLO_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic        wb_ack_i = 1'b0;
    logic        debug_led;

    int n_checks = 0;
    int n_pass   = 0;
    logic led_exp = 1'b0;

    always #5 sys_clk = ~sys_clk;

    hello_master #(.TIMEOUT(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .debug_led (debug_led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled and inputs are driven on the falling edge.
    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        check("ready_before_accept", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic write_zero_wait(input logic [31:0] adr, input logic [31:0] dat);
        issue(1'b1, adr, dat);
        check("wr_stb", wb_stb_o, 1);
        check("wr_cyc", wb_cyc_o, 1);
        check("wr_we", wb_we_o, 1);
        check("wr_adr", wb_adr_o, adr);
        check("wr_dat", wb_dat_o, dat);
        check("wr_sel", wb_sel_o, 32'hF);
        check("wr_ready_busy", cmd_ready, 0);
        check("wr_no_rsp_yet", rsp_valid, 0);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        led_exp = ~led_exp;
        check("wr_stb_low", wb_stb_o, 0);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_led", debug_led, led_exp);
        check("wr_ready_resp", cmd_ready, 0);
        step();
        check("wr_rsp_pulse_end", rsp_valid, 0);
        check("wr_ready_again", cmd_ready, 1);
    endtask

    initial begin
        logic [31:0] rd_prev;

        // Reset state
        step();
        check("rst_ready", cmd_ready, 1);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_dat", rsp_dat, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_led", debug_led, 0);
        sys_rst_n = 1'b1;
        step();

        // Stray ack while idle must be ignored
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        step();
        wb_ack_i = 1'b0;
        step();
        check("idle_ack_no_rsp", rsp_valid, 0);
        check("idle_ack_rsp_dat", rsp_dat, 0);

        // Zero-wait write
        write_zero_wait(32'h6000_0004, 32'h0000_0001);

        // Read with ack in the third stb cycle
        issue(1'b0, 32'h6000_0010, 32'h0);
        wb_dat_i = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            check("rd_stb_high", wb_stb_o, 1);
            check("rd_we", wb_we_o, 0);
            check("rd_ready_busy", cmd_ready, 0);
            if (i == 2) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'h0000_FFFF;
            end
            step();
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        led_exp = ~led_exp;
        check("rd_stb_low", wb_stb_o, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_dat", rsp_dat, 32'h0000_FFFF);
        check("rd_ready_resp", cmd_ready, 0);
        check("rd_led", debug_led, led_exp);
        step();
        check("rd_ready_again", cmd_ready, 1);
        check("rd_rsp_end", rsp_valid, 0);

        // Back-to-back with cmd_valid held high
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0000_0100;
        cmd_dat   = 32'h1111_2222;
        step();
        cmd_we  = 1'b0;
        cmd_adr = 32'h0000_0200;
        check("b2b_first_adr", wb_adr_o, 32'h0000_0100);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        led_exp = ~led_exp;
        check("b2b_rsp1", rsp_valid, 1);
        check("b2b_not_taken_in_resp", cmd_ready, 0);
        step();
        check("b2b_ready_after_rsp", cmd_ready, 1);
        check("b2b_cyc_idle", wb_cyc_o, 0);
        step();
        cmd_valid = 1'b0;
        check("b2b_second_stb", wb_stb_o, 1);
        check("b2b_second_adr", wb_adr_o, 32'h0000_0200);
        check("b2b_second_we", wb_we_o, 0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_1234;
        step();
        wb_ack_i = 1'b0;
        led_exp = ~led_exp;
        check("b2b_rsp2", rsp_valid, 1);
        check("b2b_rsp2_dat", rsp_dat, 32'h0000_1234);
        check("b2b_led_back", debug_led, 0);
        step();

`ifdef HELLO_MASTER_TIMEOUT_EN
        // No ack: abort after exactly TO stb cycles
        rd_prev = rsp_dat;
        issue(1'b0, 32'h0000_0300, 32'h0);
        wb_dat_i = 32'h5A5A_5A5A;
        for (int i = 0; i < TO; i++) begin
            check("to_stb_high", wb_stb_o, 1);
            step();
        end
        led_exp = ~led_exp;
        check("to_stb_low", wb_stb_o, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_dat_kept", rsp_dat, rd_prev);
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        step();
        check("to_late_ack_no_rsp", rsp_valid, 0);
        check("to_late_ack_dat", rsp_dat, rd_prev);

        // Ack in the last allowed stb cycle completes normally
        issue(1'b0, 32'h0000_0304, 32'h0);
        for (int i = 0; i < TO; i++) begin
            check("to_ack_stb_high", wb_stb_o, 1);
            if (i == TO - 1) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 32'h0000_4444;
            end
            step();
        end
        wb_ack_i = 1'b0;
        led_exp = ~led_exp;
        check("to_ack_rsp_valid", rsp_valid, 1);
        check("to_ack_rsp_err", rsp_err, 0);
        check("to_ack_rsp_dat", rsp_dat, 32'h0000_4444);
        step();
`else
        rd_prev = rsp_dat;
        check("no_to_err_tied", rsp_err, 0);
        check("no_to_dat_kept", rd_prev, 32'h0000_1234);
`endif

        // Reset during BUS drops cyc/stb without a clock edge
        issue(1'b1, 32'h0000_0400, 32'h0000_0009);
        check("mid_rst_stb_before", wb_stb_o, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_no_rsp", rsp_valid, 0);
        led_exp = 1'b0;
        step();
        sys_rst_n = 1'b1;
        step();
        check("post_rst_no_rsp", rsp_valid, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_led", debug_led, 0);
        write_zero_wait(32'h6000_0004, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hello_master.md
HELLO_MASTER -- requirements
Module: hello_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles with STB asserted before the cycle is aborted (range 1..65535).
REQ-002 SHALL have port sys_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_we, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr, input, 32, target byte address.
REQ-008 SHALL have port cmd_dat, input, 32, write data.
REQ-009 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rsp_dat, output, 32, read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1, timeout flag, valid with rsp_valid.
REQ-012 SHALL have ports wb_adr_o (32), wb_dat_o (32), wb_sel_o (4), wb_cyc_o (1), wb_stb_o (1) and wb_we_o (1), all outputs, forming the Wishbone classic initiator side.
REQ-013 SHALL have ports wb_dat_i (32) and wb_ack_i (1), both inputs, driven by the Wishbone responder.
REQ-014 SHALL have port debug_led, output, 1, toggles on every completed command.

Function
REQ-015 SHALL implement FSM states IDLE, BUS and RESP; all outputs registered except cmd_ready.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE (combinational from state).
REQ-017 IDLE: on cmd_valid & cmd_ready, SHALL latch cmd_adr/cmd_dat/cmd_we into wb_adr_o/wb_dat_o/wb_we_o and set wb_cyc_o = wb_stb_o = 1, wb_sel_o = 4'hF, next state BUS.
REQ-018 BUS: cyc/stb/adr/dat/we SHALL stay stable until termination.
REQ-019 BUS: on wb_ack_i = 1 SHALL clear cyc/stb at that edge, capture wb_dat_i into rsp_dat if wb_we_o = 0 (write leaves rsp_dat unchanged), clear rsp_err, next state RESP.
REQ-020 RESP: SHALL hold rsp_valid = 1 for exactly one cycle, toggle debug_led, then return to IDLE; there is no back-pressure on the response.
REQ-021 Latency SHALL be: command accepted at edge N, stb high in cycle N+1, ack sampled at edge M, rsp_valid high in cycle M+1, cmd_ready high again in cycle M+2; a zero-wait responder gives M = N+1.
REQ-022 wb_ack_i SHALL be ignored outside BUS.
REQ-023 A cmd_valid presented outside IDLE SHALL NOT be accepted and SHALL NOT be dropped; it is accepted once IDLE is reached if still asserted.

Reset
REQ-024 On sys_rst_n = 0, asynchronously: state = IDLE; wb_cyc_o = wb_stb_o = wb_we_o = 0; wb_adr_o = wb_dat_o = 0; wb_sel_o = 0; rsp_valid = rsp_err = 0; rsp_dat = 0; debug_led = 0; timeout counter = 0.
REQ-025 Reset asserted mid-cycle (in BUS) SHALL drop cyc/stb immediately and SHALL NOT produce rsp_valid.

Configuration
REQ-026 Macro HELLO_MASTER_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to BUS and increment each BUS cycle without ack; when it equals TIMEOUT-1 without ack, the block SHALL clear cyc/stb, set rsp_err = 1, leave rsp_dat unchanged and go to RESP. Ack in the same cycle wins (normal completion, rsp_err = 0).
REQ-027 Macro undefined: no counter SHALL be present, rsp_err SHALL be tied 0, and BUS SHALL wait indefinitely for ack.

Verification
REQ-028 Write cmd_adr=32'h6000_0004, cmd_dat=32'h0000_0001, zero-wait responder -> stb high 1 cycle with we=1, adr/dat as given, sel=4'hF; rsp_valid pulse 2 cycles after acceptance; rsp_err=0; debug_led 0->1.
REQ-029 Read with ack delayed 3 cycles, wb_dat_i=32'h0000_FFFF at ack -> stb high 3 cycles then low; rsp_dat=32'h0000_FFFF with rsp_valid; cmd_ready low until the cycle after rsp_valid.
REQ-030 Back-to-back: cmd_valid held high with two commands -> second accepted exactly in the cycle after rsp_valid of the first; debug_led returns to 0.
REQ-031 TIMEOUT_EN, TIMEOUT=4, no ack -> stb high exactly 4 cycles; rsp_valid with rsp_err=1; rsp_dat unchanged; ack arriving afterwards ignored.
REQ-032 TIMEOUT_EN, TIMEOUT=4, ack in 4th stb cycle -> normal completion with rsp_err=0.
REQ-033 sys_rst_n pulsed low during BUS -> cyc/stb 0 without waiting for a clock edge; no rsp_valid; next command behaves per REQ-028.
